// File: rtl/alu_pkg.sv
// alu_pkg: div-class op codes, divider FSM states and iteration counts.
package alu_pkg;
    localparam logic [5:0] ALU_DIV  = 6'd6;
    localparam logic [5:0] ALU_DIVU = 6'd7;
    localparam logic [5:0] ALU_REM  = 6'd8;
    localparam logic [5:0] ALU_REMU = 6'd9;
    localparam int ALU_W_BIT = 5;
    localparam int DIV_CNT_W = 7;
    localparam logic [DIV_CNT_W-1:0] DIV_ITER_64 = 7'd64;
    localparam logic [DIV_CNT_W-1:0] DIV_ITER_32 = 7'd32;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_FIX, S_HOLD} div_state_t;

    // Low five bits of the op code; bit 5 only selects the W variant.
    function automatic logic is_div_op(input logic [4:0] c);
        return {1'b0, c} inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    endfunction
endpackage

// File: rtl/div_core.sv
// div_core: unsigned radix-2 restoring divider, one quotient bit per step.
module div_core
    import alu_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 step,
    input  logic [DIV_CNT_W-1:0] cnt_in,
    input  logic [63:0]          dividend,
    input  logic [63:0]          divisor,
    output logic                 last,
    output logic [63:0]          quo,
    output logic [63:0]          rem
);
    logic [63:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
    logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
    logic [64:0] trial;

    // rem < divisor always holds, so bit 64 of the trial is a clean borrow flag.
    always_comb begin
        trial = {rem_q, quo_q[63]} - {1'b0, dvs_q};
        quo_d = quo_q;
        rem_d = rem_q;
        dvs_d = dvs_q;
        cnt_d = cnt_q;
        if (start) begin
            quo_d = dividend;
            rem_d = '0;
            dvs_d = divisor;
            cnt_d = cnt_in;
        end else if (step) begin
            quo_d = {quo_q[62:0], !trial[64]};
            rem_d = trial[64] ? {rem_q[62:0], quo_q[63]} : trial[63:0];
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else begin
            quo_q <= quo_d;
            rem_q <= rem_d;
            dvs_q <= dvs_d;
            cnt_q <= cnt_d;
        end
    end

    assign last = cnt_q == DIV_CNT_W'(1);
    assign quo  = quo_q;
    assign rem  = rem_q;
endmodule

// File: rtl/div_sched.sv
// div_sched: shares one iterative divider between two execute lanes, lane 1 first.
// DIV_W_FASTPATH_EN: W ops run 32 iterations on pre-shifted operands.
module div_sched
    import alu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flushE,
    input  logic            advE,
    input  logic            ReqE1,
    input  logic            ReqE2,
    input  logic [5:0]      ALUControlE1,
    input  logic [5:0]      ALUControlE2,
    input  logic [XLEN-1:0] SrcAE1,
    input  logic [XLEN-1:0] SrcBE1,
    input  logic [XLEN-1:0] SrcAE2,
    input  logic [XLEN-1:0] SrcBE2,
    output logic            StallDiv,
    output logic            DivDoneE1,
    output logic            DivDoneE2,
    output logic [XLEN-1:0] DivResultE1,
    output logic [XLEN-1:0] DivResultE2
);
    div_state_t state_q, state_d;
    logic lane_q, lane_d, pend2_q, pend2_d, done1_q, done1_d, done2_q, done2_d;
    logic special_q, special_d, wop_q, wop_d, remop_q, remop_d;
    logic negquo_q, negquo_d, negrem_q, negrem_d;
    logic [63:0] res1_q, res1_d, res2_q, res2_d, spec_q, spec_d;
    logic req1, req2, w, sgn, rem_op, neg_a, neg_b, div0, ovf;
    logic core_start, core_step, core_last;
    logic [5:0] code;
    logic [63:0] a, b, a_x, b_x, mag_a, mag_b, core_a, core_quo, core_rem, raw, fixed;
    logic [DIV_CNT_W-1:0] core_cnt;

    assign req1     = ReqE1 & is_div_op(ALUControlE1[4:0]) & !done1_q;
    assign req2     = ReqE2 & is_div_op(ALUControlE2[4:0]) & !done2_q;
    assign StallDiv = req1 | req2;
    assign code     = lane_q ? ALUControlE2 : ALUControlE1;
    assign a        = lane_q ? SrcAE2 : SrcAE1;
    assign b        = lane_q ? SrcBE2 : SrcBE1;

    always_comb begin
        w      = code[ALU_W_BIT];
        sgn    = {1'b0, code[4:0]} inside {ALU_DIV, ALU_REM};
        rem_op = {1'b0, code[4:0]} inside {ALU_REM, ALU_REMU};
        a_x    = w ? {{32{sgn & a[31]}}, a[31:0]} : a;
        b_x    = w ? {{32{sgn & b[31]}}, b[31:0]} : b;
        neg_a  = sgn & a_x[63];
        neg_b  = sgn & b_x[63];
        mag_a  = neg_a ? -a_x : a_x;
        mag_b  = neg_b ? -b_x : b_x;
        div0   = b_x == '0;
        ovf    = sgn && b_x == '1 && a_x == (w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000);
`ifdef DIV_W_FASTPATH_EN
        core_a   = w ? {mag_a[31:0], 32'b0} : mag_a;
        core_cnt = w ? DIV_ITER_32 : DIV_ITER_64;
`else
        core_a   = mag_a;
        core_cnt = DIV_ITER_64;
`endif
        raw   = special_q ? spec_q : remop_q ? (negrem_q ? -core_rem : core_rem)
                                             : (negquo_q ? -core_quo : core_quo);
        fixed = wop_q ? {{32{raw[31]}}, raw[31:0]} : raw;
    end

    always_comb begin
        state_d    = state_q;
        lane_d     = lane_q;
        pend2_d    = pend2_q;
        done1_d    = done1_q;
        done2_d    = done2_q;
        res1_d     = res1_q;
        res2_d     = res2_q;
        spec_d     = spec_q;
        special_d  = special_q;
        wop_d      = wop_q;
        remop_d    = remop_q;
        negquo_d   = negquo_q;
        negrem_d   = negrem_q;
        core_start = 1'b0;
        core_step  = 1'b0;
        case (state_q)
            S_IDLE: if (req1 | req2) begin
                state_d = S_LOAD;
                lane_d  = !req1;
                pend2_d = req1 & req2;
            end
            S_LOAD: begin
                core_start = 1'b1;
                wop_d      = w;
                remop_d    = rem_op;
                negquo_d   = neg_a ^ neg_b;
                negrem_d   = neg_a;
                special_d  = div0 | ovf;
                spec_d     = div0 ? (rem_op ? a_x : '1) : (rem_op ? '0 : a_x);
                state_d    = (div0 | ovf) ? S_FIX : S_RUN;
            end
            S_RUN: begin
                core_step = 1'b1;
                state_d   = core_last ? S_FIX : S_RUN;
            end
            S_FIX: begin
                res1_d  = lane_q ? res1_q : fixed;
                res2_d  = lane_q ? fixed : res2_q;
                done1_d = done1_q | !lane_q;
                done2_d = done2_q | lane_q;
                state_d = (pend2_q && !lane_q) ? S_LOAD : S_HOLD;
                lane_d  = lane_q | pend2_q;
                pend2_d = 1'b0;
            end
            S_HOLD: if (advE) begin
                done1_d = 1'b0;
                done2_d = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (flushE) begin
            state_d = S_IDLE;
            pend2_d = 1'b0;
            done1_d = 1'b0;
            done2_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            lane_q    <= 1'b0;
            pend2_q   <= 1'b0;
            done1_q   <= 1'b0;
            done2_q   <= 1'b0;
            res1_q    <= '0;
            res2_q    <= '0;
            spec_q    <= '0;
            special_q <= 1'b0;
            wop_q     <= 1'b0;
            remop_q   <= 1'b0;
            negquo_q  <= 1'b0;
            negrem_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            lane_q    <= lane_d;
            pend2_q   <= pend2_d;
            done1_q   <= done1_d;
            done2_q   <= done2_d;
            res1_q    <= res1_d;
            res2_q    <= res2_d;
            spec_q    <= spec_d;
            special_q <= special_d;
            wop_q     <= wop_d;
            remop_q   <= remop_d;
            negquo_q  <= negquo_d;
            negrem_q  <= negrem_d;
        end
    end

    div_core u_core (
        .clk      (clk),
        .reset    (reset),
        .start    (core_start),
        .step     (core_step),
        .cnt_in   (core_cnt),
        .dividend (core_a),
        .divisor  (mag_b),
        .last     (core_last),
        .quo      (core_quo),
        .rem      (core_rem)
    );

    assign DivDoneE1   = done1_q;
    assign DivDoneE2   = done2_q;
    assign DivResultE1 = res1_q;
    assign DivResultE2 = res2_q;
endmodule

// File: tb/tb_div_sched.sv
// tb_div_sched: scoreboard bench for div_sched against a RISC-V arithmetic model.
module tb_div_sched;
    logic clk = 0, reset = 1, flushE = 0, advE = 0, ReqE1 = 0, ReqE2 = 0;
    logic [5:0] ALUControlE1 = 0, ALUControlE2 = 0;
    logic [63:0] SrcAE1 = 0, SrcBE1 = 0, SrcAE2 = 0, SrcBE2 = 0;
    logic StallDiv, DivDoneE1, DivDoneE2;
    logic [63:0] DivResultE1, DivResultE2;
    int cyc = 0, passed = 0, total = 0;
    logic d1p = 0, d2p = 0;
    logic [5:0] o1, o2;
    logic [63:0] a1, b1, a2, b2;

    typedef struct { logic [63:0] val; int at; } exp_t;
    exp_t q1[$], q2[$];

`ifdef DIV_W_FASTPATH_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    div_sched dut (
        .clk(clk), .reset(reset), .flushE(flushE), .advE(advE),
        .ReqE1(ReqE1), .ReqE2(ReqE2),
        .ALUControlE1(ALUControlE1), .ALUControlE2(ALUControlE2),
        .SrcAE1(SrcAE1), .SrcBE1(SrcBE1), .SrcAE2(SrcAE2), .SrcBE2(SrcBE2),
        .StallDiv(StallDiv), .DivDoneE1(DivDoneE1), .DivDoneE2(DivDoneE2),
        .DivResultE1(DivResultE1), .DivResultE2(DivResultE2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    function automatic logic is_special(input logic [5:0] op, input logic [63:0] a, input logic [63:0] b);
        logic s;
        s = op[4:0] == 5'd6 || op[4:0] == 5'd8;
        if (op[5]) return b[31:0] == 0 || (s && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
        return b == 0 || (s && a == 64'h8000_0000_0000_0000 && b == '1);
    endfunction

    function automatic int lat(input logic [5:0] op, input logic [63:0] a, input logic [63:0] b);
        if (is_special(op, a, b)) return 3;
        return (op[5] && FAST) ? 35 : 67;
    endfunction

    // RISC-V semantics using plain language arithmetic; special cases first.
    function automatic logic [63:0] ref_res(input logic [5:0] op, input logic [63:0] a, input logic [63:0] b);
        int sa, sb;
        int unsigned ua, ub;
        longint la, lb;
        longint unsigned xa, xb;
        logic [31:0] r32;
        logic [63:0] r64;
        logic ovf;
        if (op[5]) begin
            sa = a[31:0]; sb = b[31:0]; ua = a[31:0]; ub = b[31:0];
            ovf = a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF;
            if (op[4:0] == 5'd6) begin
                if (sb == 0) r32 = '1; else if (ovf) r32 = a[31:0]; else r32 = sa / sb;
            end else if (op[4:0] == 5'd7) begin
                if (ub == 0) r32 = '1; else r32 = ua / ub;
            end else if (op[4:0] == 5'd8) begin
                if (sb == 0) r32 = a[31:0]; else if (ovf) r32 = 0; else r32 = sa % sb;
            end else begin
                if (ub == 0) r32 = ua; else r32 = ua % ub;
            end
            return {{32{r32[31]}}, r32};
        end
        la = a; lb = b; xa = a; xb = b;
        ovf = a == 64'h8000_0000_0000_0000 && b == '1;
        if (op[4:0] == 5'd6) begin
            if (lb == 0) r64 = '1; else if (ovf) r64 = a; else r64 = la / lb;
        end else if (op[4:0] == 5'd7) begin
            if (xb == 0) r64 = '1; else r64 = xa / xb;
        end else if (op[4:0] == 5'd8) begin
            if (lb == 0) r64 = a; else if (ovf) r64 = 0; else r64 = la % lb;
        end else begin
            if (xb == 0) r64 = xa; else r64 = xa % xb;
        end
        return r64;
    endfunction

    always @(negedge clk) begin
        if (DivDoneE1 && !d1p) begin
            check("done1_expected", 64'(q1.size() != 0), 1);
            if (q1.size() != 0) begin
                check("res1", DivResultE1, q1[0].val);
                check("done1_cycle", 64'(cyc), 64'(q1[0].at));
                q1.delete(0);
            end
        end
        if (DivDoneE2 && !d2p) begin
            check("done2_expected", 64'(q2.size() != 0), 1);
            if (q2.size() != 0) begin
                check("res2", DivResultE2, q2[0].val);
                check("done2_cycle", 64'(cyc), 64'(q2[0].at));
                q2.delete(0);
            end
        end
        d1p <= DivDoneE1;
        d2p <= DivDoneE2;
    end

    task automatic run(input logic r1, input logic [5:0] op1, input logic [63:0] x1, input logic [63:0] y1,
                       input logic r2, input logic [5:0] op2, input logic [63:0] x2, input logic [63:0] y2);
        int c0, l1, l2, last, stalls, n;
        @(negedge clk);
        ReqE1 = r1; ALUControlE1 = op1; SrcAE1 = x1; SrcBE1 = y1;
        ReqE2 = r2; ALUControlE2 = op2; SrcAE2 = x2; SrcBE2 = y2;
        c0 = cyc;
        l1 = lat(op1, x1, y1);
        l2 = r1 ? l1 + lat(op2, x2, y2) - 1 : lat(op2, x2, y2);
        if (r1) q1.push_back('{ref_res(op1, x1, y1), c0 + l1});
        if (r2) q2.push_back('{ref_res(op2, x2, y2), c0 + l2});
        last = r2 ? l2 : l1;
        stalls = 0;
        n = 0;
        #1;
        while (!((!r1 || DivDoneE1) && (!r2 || DivDoneE2)) && n < 300) begin
            stalls += int'(StallDiv);
            @(negedge clk);
            #1;
            n++;
        end
        check("wait_done", 64'(n < 300), 1);
        check("stall_cycles", 64'(stalls), 64'(last));
        check("stall_low_at_done", 64'(StallDiv), 0);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        #1;
        check("done_held", 64'({DivDoneE1, DivDoneE2}), 64'({r1, r2}));
        ReqE1 = 0; ReqE2 = 0; advE = 1;
        @(negedge clk);
        advE = 0;
        #1;
        check("done_released", 64'({DivDoneE1, DivDoneE2}), 0);
    endtask

    task automatic rand_op(output logic [5:0] op, output logic [63:0] a, output logic [63:0] b);
        op = 6'(6 + $urandom_range(0, 3)) | ($urandom_range(0, 1) != 0 ? 6'd32 : 6'd0);
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        case ($urandom_range(0, 5))
            1: begin a = 64'($urandom_range(0, 1000)); b = 64'($urandom_range(1, 20)); end
            2: b = 0;
            3: begin a = op[5] ? 64'h8000_0000 : 64'h8000_0000_0000_0000; b = '1; end
            4: begin a = -64'($urandom_range(1, 1000)); b = 64'($urandom_range(1, 20)); end
            5: b = {32'b0, $urandom} >> $urandom_range(0, 31);
            default: ;
        endcase
    endtask

    initial begin
        int c0, n;
        repeat (3) @(negedge clk);
        check("rst_done1", 64'(DivDoneE1), 0);
        check("rst_done2", 64'(DivDoneE2), 0);
        check("rst_res1", DivResultE1, 0);
        check("rst_res2", DivResultE2, 0);
        check("rst_stall", 64'(StallDiv), 0);
        reset = 0;

        run(1, 6'd7, 100, 7, 0, 0, 0, 0);
        check("divu_100_7", DivResultE1, 64'd14);
        run(1, 6'd8, -7, 2, 0, 0, 0, 0);
        check("rem_m7_2", DivResultE1, 64'hFFFF_FFFF_FFFF_FFFF);
        run(0, 0, 0, 0, 1, 6'd6, 5, 0);
        check("div_5_0", DivResultE2, 64'hFFFF_FFFF_FFFF_FFFF);
        run(1, 6'd6, 64'h8000_0000_0000_0000, '1, 0, 0, 0, 0);
        check("div_min_m1", DivResultE1, 64'h8000_0000_0000_0000);
        run(1, 6'd40, 64'h8000_0000, 64'hFFFF_FFFF, 0, 0, 0, 0);
        check("remw_min_m1", DivResultE1, 0);
        run(1, 6'd7, 100, 7, 1, 6'd9, 100, 7);
        check("dual_res1", DivResultE1, 64'd14);
        check("dual_res2", DivResultE2, 64'd2);

        // Flush mid-operation: no done, results keep their old value.
        @(negedge clk);
        ReqE1 = 1; ALUControlE1 = 6'd6; SrcAE1 = 1000; SrcBE1 = 3;
        repeat (30) @(negedge clk);
        flushE = 1;
        @(negedge clk);
        flushE = 0;
        #1;
        check("flush_stall_follows_req", 64'(StallDiv), 1);
        check("flush_keeps_res1", DivResultE1, 64'd14);
        ReqE1 = 0;
        #1;
        check("flush_stall_dropped", 64'(StallDiv), 0);
        n = 0;
        repeat (80) begin
            @(negedge clk);
            n += int'(DivDoneE1);
        end
        check("flush_no_done", 64'(n), 0);

        // Reset mid-operation clears every output.
        @(negedge clk);
        ReqE1 = 1; ALUControlE1 = 6'd6; SrcAE1 = 1000; SrcBE1 = 3;
        c0 = cyc;
        repeat (40) @(negedge clk);
        reset = 1; ReqE1 = 0;
        @(negedge clk);
        #1;
        check("mid_rst_cycle", 64'(cyc - c0), 41);
        check("mid_rst_res1", DivResultE1, 0);
        check("mid_rst_res2", DivResultE2, 0);
        check("mid_rst_done", 64'({DivDoneE1, DivDoneE2}), 0);
        check("mid_rst_stall", 64'(StallDiv), 0);
        reset = 0;

        run(1, 6'd38, -100, 7, 0, 0, 0, 0);
        check("divw_m100_7", DivResultE1, 64'hFFFF_FFFF_FFFF_FFF2);

        for (int i = 0; i < 24; i++) begin
            int pat;
            pat = $urandom_range(1, 3);
            rand_op(o1, a1, b1);
            rand_op(o2, a2, b2);
            run(pat[0], o1, a1, b1, pat[1], o2, a2, b2);
        end

        repeat (2) @(negedge clk);
        check("queues_empty", 64'(q1.size() + q2.size()), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/div_sched.md
# div_sched

Shared iterative divide/remainder scheduler for the two-lane execute stage. Owns a single multi-cycle radix-2 divider, arbitrates it between lane 1 and lane 2 div/rem requests (lane 1 = older, first), raises a stall to the hazard unit until each requesting lane has its result, and holds results until the E stage advances. It replaces the single-cycle `/` and `%` paths of the lane ALUs with a pipelinable, timing-closed unit.

## Interface
- `XLEN`, 64, operand/result width; only 64 supported.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `flushE`  in  1  squash the E stage; aborts any in-flight operation.
- `advE`  in  1  E stage advances this cycle (`enableE & !StallE` upstream); releases held results.
- `ReqE1`, `ReqE2`  in  1  lane issues a div-class op this cycle.
- `ALUControlE1`, `ALUControlE2`  in  6  op code: 6 div, 7 divu, 8 rem, 9 remu; bit5 set = W variant (38–41).
- `SrcAE1`, `SrcBE1`, `SrcAE2`, `SrcBE2`  in  64  forwarded dividend/divisor.
- `StallDiv`  out  1  hold the front end and E stage.
- `DivDoneE1`, `DivDoneE2`  out  1  lane result valid.
- `DivResultE1`, `DivResultE2`  out  64  lane result.

## Operation
- States: IDLE, LOAD, RUN, FIX, HOLD. Latch `lane` selector (1 or 2) and `pend2` flag.
- IDLE: if `ReqN` with code in {6–9, 38–41} and `!DivDoneEN`: go LOAD with lane 1 if requesting, else lane 2; set `pend2` if both request. Other codes are not requests.
- LOAD: latch operands of selected lane. W ops use low 32 bits, sign- or zero-extended per op. Signed ops take magnitudes and record quotient/remainder signs. Divisor 0 or signed overflow (MIN / -1) precompute the result and go FIX. Otherwise go RUN with count = 64.
- RUN: one restoring step per cycle. Decrement count; at 0 go FIX.
- FIX: apply signs and select quotient or remainder. W results are sign-extended from bit 31. Write `DivResultEN`; set `DivDoneEN`.
  - If `pend2` and the finished lane was 1: clear `pend2`, go LOAD for lane 2.
  - Else go HOLD.
- HOLD: on `advE` clear both done flags, go IDLE.
- Special results (RISC-V):
  - x/0: quotient = all ones; remainder = dividend.
  - MIN/-1: quotient = MIN; remainder = 0.
  - The same rules apply to W variants at 32 bits.
- `StallDiv = (ReqE1 & valid1 & !DivDoneE1) | (ReqE2 & valid2 & !DivDoneE2)`, where `validN` means the code is a div code. It is combinational, so it is high in the request cycle.
- Operands must stay stable while `StallDiv` is high. The hazard unit never pairs a lane-2 div dependent on lane 1.
- `flushE`: next state IDLE; clear `pend2` and done flags; results keep their value. It has priority over everything except `reset`.
- `reset`: state IDLE, `pend2` = 0. All outputs are 0 after reset (`StallDiv` follows its combinational equation).

## Timing
- Cycle 0 = request cycle in IDLE.
- Single normal op: LOAD in cycle 1, RUN in cycles 2–65, FIX in 66. `DivDoneEN` is high and `StallDiv` low in cycle 67. Latency is 67 cycles.
- Special case: LOAD in 1, FIX in 2, done in cycle 3.
- Dual request: lane 1 done at 67, lane 2 LOAD at 67, lane 2 done at 133. `StallDiv` is high in cycles 0–132.
- Results are stable from done until the cycle after `advE`.
- A `ReqN` arriving while not IDLE is serviced after HOLD → IDLE; `StallDiv` covers the wait.

## Configuration
- `DIV_W_FASTPATH_EN` defined: W ops load count = 32 with operands pre-shifted. Single W op completes in cycle 35; 64-bit ops unchanged.
- Undefined: W ops use the 64-cycle path, with results identical.

## Structure
- `alu_pkg`: op-code constants (`ALU_DIV`=6, `ALU_DIVU`, `ALU_REM`, `ALU_REMU`, `ALU_W_BIT`=5), `div_state_t` enum, and the iteration-count constants.
- Sub-module `div_core`: unsigned restoring divider. It has start/count/step, quotient and remainder registers, and no sign logic. The FSM and sign handling stay in `div_sched`.

## Test plan
- Lane 1 divu 100/7 → `StallDiv` high in cycles 0–66; `DivDoneE1` and `DivResultE1` = 14 in cycle 67.
- Lane 1 rem -7 % 2 → `DivResultE1` = 0xFFFF_FFFF_FFFF_FFFF at cycle 67. Lane 2 div 5/0 alone → `DivResultE2` = all ones at cycle 3.
- div 0x8000_0000_0000_0000 / -1 → 0x8000_0000_0000_0000 at cycle 3. remw 0x8000_0000 / 0xFFFF_FFFF → 0 at cycle 3.
- Both lanes, lane 1 divu 100/7 and lane 2 remu 100/7 → done1 = 14 at 67, done2 = 2 at 133. `StallDiv` low from 133; results held until `advE`.
- `flushE` at cycle 30 of a 64-bit div → IDLE at 31, no done, `StallDiv` follows the request. `reset` at cycle 40 → all outputs 0 at 41.
- With `DIV_W_FASTPATH_EN`, divw -100/7 → 0xFFFF_FFFF_FFFF_FFF2 at cycle 35. Without it, the same result at cycle 67.
